k12a_bus_arbiter: RTL
=====================

K12A_BUS_ARBITER -- requirements
Module: k12a_bus_arbiter

Interface
REQ-001 SHALL have one clock and an asynchronous active-high reset, ports clock and reset.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high.
- cpu_mem_enable  in  1  CPU FSM requests memory this cycle.
- cpu_mem_write  in  1  CPU request is a write; valid with cpu_mem_enable.
- cpu_hold  out  1  CPU state register and all CPU stores frozen this cycle.
- async_write  out  1  memory write strobe, shared by CPU and DMA paths.
- dma_req  in  1  DMA transfer request; level.
- dma_write  in  1  1 = write, 0 = read; sampled at grant.
- dma_addr  in  16  DMA address; sampled at grant.
- dma_wdata  in  8  DMA write data; sampled at grant.
- mem_data_in  in  8  data bus value returned from memory.
- dma_ack  out  1  one-cycle pulse: DMA transfer complete.
- dma_rdata  out  8  read data captured for the last DMA read.
- owner  out  owner_t  bus owner, OWNER_CPU or OWNER_DMA.
- dma_addr_bus  out  16  latched DMA address; drives addr bus when owner = OWNER_DMA.
- dma_data_bus  out  8  latched DMA write data.
- dma_mem_enable  out  1  memory enable for the DMA path.

Function
REQ-003 States SHALL be ARB_IDLE, ARB_CPU_WSTROBE, ARB_DMA_SETUP, ARB_DMA_XFER and ARB_DMA_ACK.
REQ-004 In ARB_IDLE with cpu_mem_enable=1 and cpu_mem_write=0: owner=CPU, cpu_hold=0, state stays ARB_IDLE (zero-latency read).
REQ-005 In ARB_IDLE with a CPU write granted: cpu_hold=1 and async_write=0 for that setup cycle, then next state = ARB_CPU_WSTROBE.
REQ-006 ARB_CPU_WSTROBE: async_write=1, cpu_hold=0, next state = ARB_IDLE.
REQ-007 A DMA request is granted in ARB_IDLE when dma_req=1 and either cpu_mem_enable=0 or the starvation rule (REQ-015) fires.
REQ-008 On DMA grant the block SHALL latch dma_addr, dma_wdata and dma_write, and set next state = ARB_DMA_SETUP; cpu_hold=1 in the grant cycle.
REQ-009 In ARB_DMA_SETUP: owner=DMA, dma_mem_enable=1, async_write=0; next state = ARB_DMA_XFER.
REQ-010 In ARB_DMA_XFER: owner=DMA, dma_mem_enable=1, async_write = latched write; for a read, dma_rdata <= mem_data_in at the end of the cycle; next state = ARB_DMA_ACK.
REQ-011 In ARB_DMA_ACK: dma_ack=1, owner=CPU, dma_mem_enable=0; next state = ARB_IDLE.
REQ-012 cpu_hold SHALL be 1 in ARB_DMA_SETUP, ARB_DMA_XFER and ARB_DMA_ACK.
REQ-013 dma_req may drop after grant; the latched transfer SHALL still complete and ack. dma_req high during ARB_DMA_ACK SHALL NOT be evaluated until ARB_IDLE.
REQ-014 When both requesters are active in ARB_IDLE and the starvation rule does not fire, the CPU SHALL win.

Reset
REQ-016 On reset: state = ARB_IDLE, owner = OWNER_CPU; cpu_hold, async_write, dma_ack and dma_mem_enable = 0; dma_rdata, latches and counter = 0.
REQ-017 Reset mid-transfer SHALL abort it with no dma_ack, and async_write SHALL drop asynchronously.

Configuration
REQ-015 With K12A_ARB_STARVE_LIMIT_EN defined:
- a saturating counter SHALL count ARB_IDLE cycles with dma_req=1 and no grant;
- when it reaches ARB_STARVE_LIMIT (8), DMA SHALL win over CPU;
- the counter SHALL clear on grant.
REQ-018 Without K12A_ARB_STARVE_LIMIT_EN there SHALL be no counter, and DMA SHALL be granted only when cpu_mem_enable=0.

Structure
REQ-019 owner_t, the arbiter state enum and ARB_STARVE_LIMIT SHALL live in the shared k12a.inc.sv.
REQ-020 The starvation counter SHALL be sub-module k12a_arb_starve_ctr, instantiated only under the macro.

Verification
REQ-021 CPU read (cpu_mem_enable=1, write=0) in ARB_IDLE -> cpu_hold=0, owner=CPU, async_write=0 in the same cycle.
REQ-022 CPU write -> cycle 1: hold=1, async_write=0; cycle 2: hold=0, async_write=1; then ARB_IDLE.
REQ-023 DMA write, addr 0x8123, data 0x5A, CPU idle -> owner=DMA for 2 cycles, async_write=1 in the XFER cycle only, dma_addr_bus=0x8123, dma_ack on the 4th cycle after request.
REQ-024 DMA read with mem_data_in=0xC3 in XFER and dma_req dropped after grant -> dma_rdata=0xC3 and dma_ack still pulses once.
REQ-025 cpu_mem_enable and dma_req held high -> macro on: DMA granted on the 9th contended cycle; macro off: never granted.
REQ-026 Reset asserted during ARB_DMA_XFER of a write -> async_write=0 immediately, no dma_ack, state ARB_IDLE after release.

Source files
------------

// File: rtl/k12a.inc.sv
// -----------------------------------------------------------------------------
// k12a shared definitions
// Purpose : types and constants shared by the k12a bus arbiter and its helpers.
//           Holds the bus owner type, the arbiter state encoding and the DMA
//           starvation limit used when K12A_ARB_STARVE_LIMIT_EN is defined.
// Ports   : none (package only)
// -----------------------------------------------------------------------------
package k12a_pkg;

    // Who currently drives the shared address/data bus
    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_DMA = 1'b1
    } owner_t;

    // Arbiter sequencing states
    typedef enum logic [2:0] {
        ARB_IDLE        = 3'd0,
        ARB_CPU_WSTROBE = 3'd1,
        ARB_DMA_SETUP   = 3'd2,
        ARB_DMA_XFER    = 3'd3,
        ARB_DMA_ACK     = 3'd4
    } arb_state_t;

    // Number of refused contended idle cycles before DMA overrides the CPU
    localparam int ARB_STARVE_LIMIT = 8;
    localparam int ARB_STARVE_W     = $clog2(ARB_STARVE_LIMIT + 1);

endpackage

// File: rtl/k12a_arb_starve_ctr.sv
// -----------------------------------------------------------------------------
// k12a_arb_starve_ctr
// Purpose : saturating counter of idle cycles in which DMA asked for the bus
//           and was refused. Flags starvation once the count hits
//           ARB_STARVE_LIMIT so the arbiter can let DMA win over the CPU.
// Ports   : clock, reset (async, active-high)
//           i_count  - count this cycle (DMA waiting, not granted)
//           i_clear  - DMA granted, restart the count
//           o_starve - count has reached ARB_STARVE_LIMIT
// -----------------------------------------------------------------------------
module k12a_arb_starve_ctr
    import k12a_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic i_count,
    input  logic i_clear,
    output logic o_starve
);

    localparam logic [ARB_STARVE_W-1:0] LIMIT = ARB_STARVE_W'(ARB_STARVE_LIMIT);

    logic [ARB_STARVE_W-1:0] r_count;

    // Clear wins over count; the count holds at the limit until a grant clears it
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_count && (r_count != LIMIT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_starve = (r_count == LIMIT);

endmodule

// File: rtl/k12a_bus_arbiter.sv
// -----------------------------------------------------------------------------
// k12a_bus_arbiter
// Purpose : shares the memory bus between the CPU FSM and a DMA engine.
//           CPU reads pass straight through in idle; CPU writes take a setup
//           cycle then a strobe cycle; DMA transfers are latched at grant and
//           run setup -> xfer -> ack while the CPU is held.
// Config  : K12A_ARB_STARVE_LIMIT_EN - when defined, a starvation counter lets
//           DMA win over a busy CPU after ARB_STARVE_LIMIT refused idle cycles.
//           When undefined, DMA is granted only while the CPU is not asking.
// Ports   : clock, reset (async, active-high)
//           cpu_mem_enable, cpu_mem_write  - CPU request
//           cpu_hold                       - freeze CPU this cycle
//           async_write                    - shared memory write strobe
//           dma_req, dma_write, dma_addr, dma_wdata - DMA request (latched at grant)
//           mem_data_in                    - memory read data
//           dma_ack, dma_rdata             - DMA completion pulse and read data
//           owner                          - current bus owner
//           dma_addr_bus, dma_data_bus, dma_mem_enable - DMA bus drive
// -----------------------------------------------------------------------------
module k12a_bus_arbiter
    import k12a_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_mem_enable,
    input  logic        cpu_mem_write,
    output logic        cpu_hold,
    output logic        async_write,
    input  logic        dma_req,
    input  logic        dma_write,
    input  logic [15:0] dma_addr,
    input  logic [7:0]  dma_wdata,
    input  logic [7:0]  mem_data_in,
    output logic        dma_ack,
    output logic [7:0]  dma_rdata,
    output owner_t      owner,
    output logic [15:0] dma_addr_bus,
    output logic [7:0]  dma_data_bus,
    output logic        dma_mem_enable
);

    arb_state_t  r_state;
    owner_t      r_owner;
    logic        r_asyncWrite;
    logic        r_dmaMemEnable;
    logic        r_dmaAck;
    logic        r_holdState;
    logic        r_dmaWrite;
    logic [15:0] r_dmaAddr;
    logic [7:0]  r_dmaWdata;
    logic [7:0]  r_dmaRdata;

    logic        w_inIdle;
    logic        w_starve;
    logic        w_dmaGrant;
    logic        w_cpuWriteGrant;

    assign w_inIdle = (r_state == ARB_IDLE);

`ifdef K12A_ARB_STARVE_LIMIT_EN
    // Count only idle cycles where DMA waited and lost; any grant restarts it
    k12a_arb_starve_ctr u_starveCtr (
        .clock    (clock),
        .reset    (reset),
        .i_count  (w_inIdle && dma_req && !w_dmaGrant),
        .i_clear  (w_dmaGrant),
        .o_starve (w_starve)
    );
`else
    assign w_starve = 1'b0;
`endif

    // DMA wins only when the CPU is quiet or has been starving DMA too long;
    // otherwise the CPU keeps priority
    assign w_dmaGrant      = w_inIdle && dma_req && (!cpu_mem_enable || w_starve);
    assign w_cpuWriteGrant = w_inIdle && cpu_mem_enable && cpu_mem_write && !w_dmaGrant;

    // Hold is the only output that must react in the same idle cycle as the
    // request; in the DMA states it comes from the registered flag
    assign cpu_hold = r_holdState || w_dmaGrant || w_cpuWriteGrant;

    // Sequencing FSM. All bus-control outputs are registered here with the
    // value they need in the next state, so reset clears them asynchronously.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= ARB_IDLE;
            r_owner        <= OWNER_CPU;
            r_asyncWrite   <= 1'b0;
            r_dmaMemEnable <= 1'b0;
            r_dmaAck       <= 1'b0;
            r_holdState    <= 1'b0;
            r_dmaWrite     <= 1'b0;
            r_dmaAddr      <= '0;
            r_dmaWdata     <= '0;
            r_dmaRdata     <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_dmaGrant) begin
                        r_dmaWrite     <= dma_write;
                        r_dmaAddr      <= dma_addr;
                        r_dmaWdata     <= dma_wdata;
                        r_state        <= ARB_DMA_SETUP;
                        r_owner        <= OWNER_DMA;
                        r_dmaMemEnable <= 1'b1;
                        r_holdState    <= 1'b1;
                    end else if (w_cpuWriteGrant) begin
                        r_state      <= ARB_CPU_WSTROBE;
                        r_asyncWrite <= 1'b1;
                    end
                end
                ARB_CPU_WSTROBE: begin
                    r_state      <= ARB_IDLE;
                    r_asyncWrite <= 1'b0;
                end
                ARB_DMA_SETUP: begin
                    r_state      <= ARB_DMA_XFER;
                    r_asyncWrite <= r_dmaWrite;
                end
                ARB_DMA_XFER: begin
                    if (!r_dmaWrite) begin
                        r_dmaRdata <= mem_data_in;
                    end
                    r_state        <= ARB_DMA_ACK;
                    r_owner        <= OWNER_CPU;
                    r_dmaMemEnable <= 1'b0;
                    r_asyncWrite   <= 1'b0;
                    r_dmaAck       <= 1'b1;
                end
                ARB_DMA_ACK: begin
                    r_state     <= ARB_IDLE;
                    r_dmaAck    <= 1'b0;
                    r_holdState <= 1'b0;
                end
                default: begin
                    r_state        <= ARB_IDLE;
                    r_owner        <= OWNER_CPU;
                    r_asyncWrite   <= 1'b0;
                    r_dmaMemEnable <= 1'b0;
                    r_dmaAck       <= 1'b0;
                    r_holdState    <= 1'b0;
                end
            endcase
        end
    end

    assign async_write    = r_asyncWrite;
    assign dma_mem_enable = r_dmaMemEnable;
    assign dma_ack        = r_dmaAck;
    assign owner          = r_owner;
    assign dma_rdata      = r_dmaRdata;
    assign dma_addr_bus   = r_dmaAddr;
    assign dma_data_bus   = r_dmaWdata;

endmodule
